// File: rtl/kudu_dv_pkg.sv
// Shared memory-command definitions used by the data-side OBI initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package kudu_dv_pkg;

    // Bit positions inside the 8-bit sideband flag field.
    localparam int FLAG_ISR  = 0;
    localparam int FLAG_STKZ = 2;

    // Request attributes. Write data lives outside this struct because its
    // width is a module parameter and package types cannot be parameterised.
    typedef struct packed {
        logic        we;
        logic        is_cap;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [7:0]  flag;
    } mem_cmd_t;

endpackage

// File: rtl/obi_tag_fifo.sv
// In-order tag FIFO, flop-based, DEPTH entries of WIDTH bits.
// Latency: pushed entry visible at o_head_dat the cycle after the push.
// Backpressure: none; a push while full is dropped unless a pop happens in the same cycle.
// Ports: i_clk/i_rst (sync active-high), i_push/i_push_dat, i_pop, o_head_dat, o_full, o_empty.
module obi_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_head_dat = r_mem[r_rptr];
    assign w_do_pop   = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so push-while-full is legal then.
    assign w_do_push  = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_do_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/obi_data_initiator.sv
// OBI data-side initiator: one request register, in-order tag FIFO, registered responses.
// Latency: command presented on data_req 1 cycle after accept; response 1 cycle after data_rvalid.
// Backpressure: cmd_ready drops while a request is stalled or MAX_OUTSTANDING is reached; rsp_* has none.
// Ports: clk_i/rst_i (sync active-high); cmd_* command in; data_* OBI request out / response in;
//        rsp_* response out; outst_cnt granted-but-unanswered count; proto_err sticky violation flag.
module obi_data_initiator
    import kudu_dv_pkg::*;
#(
    parameter int DW              = 65,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic          cmd_is_cap,
    input  logic [3:0]    cmd_be,
    input  logic [31:0]   cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [7:0]    cmd_flag,
    output logic          data_req,
    output logic          data_we,
    output logic          data_is_cap,
    output logic [3:0]    data_be,
    output logic [31:0]   data_addr,
    output logic [DW-1:0] data_wdata,
    output logic [7:0]    data_flag,
    input  logic          data_gnt,
    input  logic          data_rvalid,
    input  logic          data_err,
    input  logic [DW-1:0] data_rdata,
    output logic          rsp_valid,
    output logic          rsp_we,
    output logic          rsp_is_cap,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_rdata,
    output logic [2:0]    outst_cnt,
    output logic          proto_err
);
    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} req_state_e;

    req_state_e    r_state;
    mem_cmd_t      r_cmd;
    logic [DW-1:0] r_wdata;
    logic [2:0]    r_outst;
    logic [2:0]    r_quiet;
    logic          r_rsp_valid;
    logic          r_rsp_we;
    logic          r_rsp_is_cap;
    logic          r_rsp_err;
    logic [DW-1:0] r_rsp_rdata;
    logic          r_proto_err;

    logic          w_req;
    logic [3:0]    w_inflight;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_spurious;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [1:0]    w_head;

    assign w_req      = (r_state == S_REQ);
    // Slots claimed: granted-unanswered plus the one waiting in the request register.
    assign w_inflight = {1'b0, r_outst} + {3'b000, w_req};
    assign cmd_ready  = ~rst_i & (~w_req | data_gnt) & (w_inflight < 4'(MAX_OUTSTANDING));
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_push     = w_req & data_gnt;
    assign w_pop      = data_rvalid & ~w_fifo_empty;
    assign w_spurious = data_rvalid & (r_outst == 3'd0);

    // Request register; attributes are cleared when it empties so idle outputs read 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cmd   <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_REQ;
                        r_cmd.we     <= cmd_we;
                        r_cmd.is_cap <= cmd_is_cap;
                        r_cmd.be     <= cmd_be;
                        r_cmd.addr   <= cmd_addr;
                        r_cmd.flag   <= cmd_flag;
                        r_wdata      <= cmd_wdata;
                    end
                end
                S_REQ: begin
                    // An accept here implies data_gnt, so the old request has left.
                    if (w_accept) begin
                        r_cmd.we     <= cmd_we;
                        r_cmd.is_cap <= cmd_is_cap;
                        r_cmd.be     <= cmd_be;
                        r_cmd.addr   <= cmd_addr;
                        r_cmd.flag   <= cmd_flag;
                        r_wdata      <= cmd_wdata;
                    end else if (data_gnt) begin
                        r_state <= S_IDLE;
                        r_cmd   <= '0;
                        r_wdata <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outstanding count, response register and protocol checker.
    // r_quiet masks stale rvalids from transactions killed by a reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outst      <= '0;
            r_quiet      <= 3'(MAX_OUTSTANDING);
            r_rsp_valid  <= 1'b0;
            r_rsp_we     <= 1'b0;
            r_rsp_is_cap <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_outst      <= r_outst + {2'b00, w_push} - {2'b00, w_pop};
            r_rsp_valid  <= w_pop;
            r_rsp_we     <= w_pop & w_head[1];
            r_rsp_is_cap <= w_pop & w_head[0];
            r_rsp_err    <= w_pop & data_err;
            // Writes return no data; reads pass the full word including the tag bit.
            r_rsp_rdata  <= (w_pop & ~w_head[1]) ? data_rdata : '0;
            if (r_quiet != 3'd0) begin
                r_quiet <= r_quiet - 3'd1;
            end
            if ((w_spurious & (r_quiet == 3'd0)) | (w_push & w_fifo_full & ~w_pop)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    obi_tag_fifo #(
        .WIDTH (2),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_push     (w_push),
        .i_push_dat ({r_cmd.we, r_cmd.is_cap}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    assign data_req    = w_req;
    assign data_we     = r_cmd.we;
    assign data_is_cap = r_cmd.is_cap;
    assign data_be     = r_cmd.be;
    assign data_addr   = r_cmd.addr;
    assign data_flag   = r_cmd.flag;
    assign data_wdata  = r_wdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_we      = r_rsp_we;
    assign rsp_is_cap  = r_rsp_is_cap;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata   = r_rsp_rdata;
    assign outst_cnt   = r_outst;
    assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_obi_data_initiator.sv
module tb_obi_data_initiator;
    localparam int DW   = 65;
    localparam int MAXO = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid, cmd_ready, cmd_we, cmd_is_cap;
    logic [3:0]    cmd_be;
    logic [31:0]   cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [7:0]    cmd_flag;
    logic          data_req, data_we, data_is_cap;
    logic [3:0]    data_be;
    logic [31:0]   data_addr;
    logic [DW-1:0] data_wdata;
    logic [7:0]    data_flag;
    logic          data_gnt, data_rvalid, data_err;
    logic [DW-1:0] data_rdata;
    logic          rsp_valid, rsp_we, rsp_is_cap, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [2:0]    outst_cnt;
    logic          proto_err;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic          we;
        logic          cap;
        logic [3:0]    be;
        logic [31:0]   addr;
        logic [DW-1:0] wdata;
        logic [7:0]    flag;
    } tcmd_t;

    // Reference model: commands waiting for grant, granted commands awaiting
    // rvalid (in issue order), and the response expected after the next edge.
    tcmd_t         m_pend[$];
    tcmd_t         m_infl[$];
    logic          m_rsp_vld, m_rsp_we, m_rsp_cap, m_rsp_err;
    logic [DW-1:0] m_rsp_rdata;

    obi_data_initiator #(.DW(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_is_cap(cmd_is_cap), .cmd_be(cmd_be),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_flag(cmd_flag),
        .data_req(data_req), .data_we(data_we), .data_is_cap(data_is_cap),
        .data_be(data_be), .data_addr(data_addr), .data_wdata(data_wdata), .data_flag(data_flag),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_err(data_err), .data_rdata(data_rdata),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_is_cap(rsp_is_cap), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .outst_cnt(outst_cnt), .proto_err(proto_err)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle_inputs();
        cmd_valid = 0; cmd_we = 0; cmd_is_cap = 0; cmd_be = '0; cmd_addr = '0;
        cmd_wdata = '0; cmd_flag = '0; data_gnt = 0; data_rvalid = 0; data_err = 0; data_rdata = '0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic tick();
        logic          acc, gev, pev, er;
        logic [DW-1:0] rd;
        tcmd_t         c, t;
        acc = cmd_valid && (m_pend.size() == 0 || data_gnt) && (m_infl.size() + m_pend.size() < MAXO);
        gev = (m_pend.size() > 0) && data_gnt;
        pev = data_rvalid && (m_infl.size() > 0);
        c   = '{we: cmd_we, cap: cmd_is_cap, be: cmd_be, addr: cmd_addr, wdata: cmd_wdata, flag: cmd_flag};
        rd  = data_rdata;
        er  = data_err;
        @(posedge clk_i);
        m_rsp_vld = pev; m_rsp_we = 0; m_rsp_cap = 0; m_rsp_err = 0; m_rsp_rdata = '0;
        if (pev) begin
            t = m_infl.pop_front();
            m_rsp_we = t.we; m_rsp_cap = t.cap; m_rsp_err = er;
            m_rsp_rdata = t.we ? '0 : rd;
        end
        if (gev) m_infl.push_back(m_pend.pop_front());
        if (acc) m_pend.push_back(c);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1; cmd_valid = 1; cmd_addr = 32'hFFFF_FFFF; data_gnt = 1; data_rvalid = 1;
        repeat (2) @(negedge clk_i);
        n_chk++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); else n_pass++;
        n_chk++; if (data_req !== 1'b0) $display("FAIL rst_data_req: got %b want 0", data_req); else n_pass++;
        n_chk++; if (data_addr !== 32'h0) $display("FAIL rst_data_addr: got %h want 0", data_addr); else n_pass++;
        n_chk++; if (outst_cnt !== 3'd0) $display("FAIL rst_outst: got %0d want 0", outst_cnt); else n_pass++;
        n_chk++; if ({rsp_valid, rsp_we, rsp_is_cap, rsp_err, proto_err} !== 5'b0)
            $display("FAIL rst_rsp_flags: got %b want 00000", {rsp_valid, rsp_we, rsp_is_cap, rsp_err, proto_err}); else n_pass++;
        idle_inputs();
        @(negedge clk_i);
        rst_i = 0;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_single_read();
        cmd_valid = 1; cmd_we = 0; cmd_is_cap = 0; cmd_be = 4'hF; cmd_addr = 32'h8000_0010; cmd_flag = 8'h01;
        #1;
        n_chk++; if (cmd_ready !== 1'b1) $display("FAIL rd_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
        @(negedge clk_i);
        cmd_valid = 0;
        n_chk++; if ({data_req, data_we, data_addr, data_flag} !== {1'b1, 1'b0, 32'h8000_0010, 8'h01})
            $display("FAIL rd_request: got req=%b we=%b addr=%h flag=%h want 1 0 80000010 01", data_req, data_we, data_addr, data_flag); else n_pass++;
        data_gnt = 1;
        @(negedge clk_i);
        data_gnt = 0;
        n_chk++; if ({data_req, outst_cnt} !== {1'b0, 3'd1}) $display("FAIL rd_after_gnt: got req=%b cnt=%0d want 0 1", data_req, outst_cnt); else n_pass++;
        @(negedge clk_i);
        @(negedge clk_i);
        data_rvalid = 1; data_rdata = DW'(64'h1234_5678); data_err = 0;
        n_chk++; if (rsp_valid !== 1'b0) $display("FAIL rd_early_rsp: got %b want 0", rsp_valid); else n_pass++;
        @(negedge clk_i);
        data_rvalid = 0;
        n_chk++; if ({rsp_valid, rsp_we, rsp_err, outst_cnt} !== {1'b1, 1'b0, 1'b0, 3'd0})
            $display("FAIL rd_rsp: got vld=%b we=%b err=%b cnt=%0d want 1 0 0 0", rsp_valid, rsp_we, rsp_err, outst_cnt); else n_pass++;
        n_chk++; if (rsp_rdata !== DW'(64'h1234_5678)) $display("FAIL rd_rdata: got %h want 12345678", rsp_rdata); else n_pass++;
        @(negedge clk_i);
        n_chk++; if (rsp_valid !== 1'b0) $display("FAIL rd_rsp_once: got %b want 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_write_stall();
        logic [DW-1:0] wd;
        wd = DW'(65'h1_DEAD_BEEF_0BAD_F00D);
        cmd_valid = 1; cmd_we = 1; cmd_is_cap = 0; cmd_be = 4'h3; cmd_addr = 32'h4000_0020; cmd_wdata = wd; cmd_flag = 8'h04;
        @(negedge clk_i);
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            n_chk++; if ({data_req, data_we, data_is_cap, data_be, data_addr, data_wdata, data_flag} !== {1'b1, 1'b1, 1'b0, 4'h3, 32'h4000_0020, wd, 8'h04})
                $display("FAIL stall_attr_%0d: got req=%b addr=%h wdata=%h be=%h flag=%h", i, data_req, data_addr, data_wdata, data_be, data_flag); else n_pass++;
            data_gnt = (i == 5);
            #1;
            if (i < 5) begin
                n_chk++; if (cmd_ready !== 1'b0) $display("FAIL stall_ready_%0d: got %b want 0", i, cmd_ready); else n_pass++;
            end
            @(negedge clk_i);
        end
        data_gnt = 0;
        n_chk++; if ({data_req, outst_cnt} !== {1'b0, 3'd1}) $display("FAIL stall_granted: got req=%b cnt=%0d want 0 1", data_req, outst_cnt); else n_pass++;
        data_rvalid = 1; data_rdata = DW'({$urandom(), $urandom(), $urandom()}) | DW'(1);
        @(negedge clk_i);
        data_rvalid = 0;
        n_chk++; if ({rsp_valid, rsp_we, rsp_is_cap, outst_cnt} !== {1'b1, 1'b1, 1'b0, 3'd0})
            $display("FAIL stall_rsp: got vld=%b we=%b cap=%b cnt=%0d want 1 1 0 0", rsp_valid, rsp_we, rsp_is_cap, outst_cnt); else n_pass++;
        n_chk++; if (rsp_rdata !== '0) $display("FAIL stall_rdata: got %h want 0", rsp_rdata); else n_pass++;
        @(negedge clk_i);
    endtask

    task automatic test_max_outstanding();
        int idx = 0;
        data_gnt = 1;
        for (int c = 0; c < 6; c++) begin
            n_chk++; if (outst_cnt > 3'd2) $display("FAIL max_cnt_%0d: got %0d want <=2", c, outst_cnt); else n_pass++;
            cmd_valid = (idx < 3); cmd_we = 0; cmd_is_cap = (idx == 2); cmd_be = 4'hF;
            cmd_addr = 32'h200 + 32'(4 * idx);
            #1;
            if (cmd_valid && cmd_ready) idx++;
            @(negedge clk_i);
        end
        n_chk++; if (idx != 2) $display("FAIL max_accepted: got %0d want 2", idx); else n_pass++;
        n_chk++; if ({data_req, outst_cnt} !== {1'b0, 3'd2}) $display("FAIL max_blocked: got req=%b cnt=%0d want 0 2", data_req, outst_cnt); else n_pass++;
        data_rvalid = 1; data_rdata = '0;
        #1;
        n_chk++; if (cmd_ready !== 1'b0) $display("FAIL max_ready_at_rvalid: got %b want 0", cmd_ready); else n_pass++;
        @(negedge clk_i);
        data_rvalid = 0;
        n_chk++; if ({data_req, outst_cnt} !== {1'b0, 3'd1}) $display("FAIL max_after_rvalid: got req=%b cnt=%0d want 0 1", data_req, outst_cnt); else n_pass++;
        #1;
        n_chk++; if (cmd_ready !== 1'b1) $display("FAIL max_ready_freed: got %b want 1", cmd_ready); else n_pass++;
        @(negedge clk_i);
        cmd_valid = 0;
        n_chk++; if ({data_req, data_is_cap, data_addr} !== {1'b1, 1'b1, 32'h208})
            $display("FAIL max_third_req: got req=%b cap=%b addr=%h want 1 1 208", data_req, data_is_cap, data_addr); else n_pass++;
        @(negedge clk_i);
        n_chk++; if (outst_cnt !== 3'd2) $display("FAIL max_third_granted: got %0d want 2", outst_cnt); else n_pass++;
        data_gnt = 0; data_rvalid = 1;
        repeat (2) @(negedge clk_i);
        data_rvalid = 0;
        n_chk++; if (outst_cnt !== 3'd0) $display("FAIL max_drained: got %0d want 0", outst_cnt); else n_pass++;
        @(negedge clk_i);
    endtask

    task automatic test_gnt_rvalid_same_cycle();
        logic [DW-1:0] d0, d1, d2;
        d0 = DW'({$urandom(), $urandom(), $urandom()});
        d1 = DW'({$urandom(), $urandom(), $urandom()}) | DW'(1);
        d2 = DW'({$urandom(), $urandom(), $urandom()});
        d2[DW-1] = 1'b1;
        cmd_valid = 1; cmd_we = 0; cmd_is_cap = 0; cmd_addr = 32'h100;
        @(negedge clk_i);
        cmd_we = 1; cmd_addr = 32'h104; data_gnt = 1;
        @(negedge clk_i);
        cmd_we = 0; cmd_is_cap = 1; cmd_addr = 32'h108;
        data_rvalid = 1; data_rdata = d0;
        @(negedge clk_i);
        data_rvalid = 0;
        n_chk++; if (outst_cnt !== 3'd1) $display("FAIL same_cnt_a: got %0d want 1", outst_cnt); else n_pass++;
        n_chk++; if ({rsp_valid, rsp_we, rsp_is_cap, rsp_rdata} !== {1'b1, 1'b0, 1'b0, d0})
            $display("FAIL same_rsp_read: got vld=%b we=%b cap=%b rdata=%h want 1 0 0 %h", rsp_valid, rsp_we, rsp_is_cap, rsp_rdata, d0); else n_pass++;
        @(negedge clk_i);
        cmd_valid = 0;
        n_chk++; if ({rsp_valid, data_req, data_is_cap} !== {1'b0, 1'b1, 1'b1})
            $display("FAIL same_cap_req: got rspv=%b req=%b cap=%b want 0 1 1", rsp_valid, data_req, data_is_cap); else n_pass++;
        data_rvalid = 1; data_rdata = d1;
        @(negedge clk_i);
        data_gnt = 0; data_rdata = d2;
        n_chk++; if (outst_cnt !== 3'd1) $display("FAIL same_cnt_b: got %0d want 1", outst_cnt); else n_pass++;
        n_chk++; if ({rsp_valid, rsp_we, rsp_is_cap, rsp_rdata} !== {1'b1, 1'b1, 1'b0, DW'(0)})
            $display("FAIL same_rsp_write: got vld=%b we=%b cap=%b rdata=%h want 1 1 0 0", rsp_valid, rsp_we, rsp_is_cap, rsp_rdata); else n_pass++;
        @(negedge clk_i);
        data_rvalid = 0;
        n_chk++; if ({rsp_valid, rsp_we, rsp_is_cap, rsp_rdata, outst_cnt} !== {1'b1, 1'b0, 1'b1, d2, 3'd0})
            $display("FAIL same_rsp_cap: got vld=%b we=%b cap=%b rdata=%h cnt=%0d want 1 0 1 %h 0", rsp_valid, rsp_we, rsp_is_cap, rsp_rdata, outst_cnt, d2); else n_pass++;
        idle_inputs();
        @(negedge clk_i);
    endtask

    task automatic test_spurious_rvalid();
        data_rvalid = 1; data_rdata = DW'(32'hBAD);
        @(negedge clk_i);
        data_rvalid = 0;
        n_chk++; if ({proto_err, rsp_valid, outst_cnt} !== {1'b1, 1'b0, 3'd0})
            $display("FAIL spur_flag: got perr=%b rspv=%b cnt=%0d want 1 0 0", proto_err, rsp_valid, outst_cnt); else n_pass++;
        repeat (4) @(negedge clk_i);
        n_chk++; if ({proto_err, rsp_valid} !== 2'b10) $display("FAIL spur_sticky: got perr=%b rspv=%b want 1 0", proto_err, rsp_valid); else n_pass++;
        rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
        n_chk++; if (proto_err !== 1'b0) $display("FAIL spur_cleared: got %b want 0", proto_err); else n_pass++;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_mid_reset();
        cmd_valid = 1; cmd_we = 0; cmd_is_cap = 0; cmd_addr = 32'h300; data_gnt = 1;
        @(negedge clk_i);
        cmd_addr = 32'h304;
        @(negedge clk_i);
        cmd_valid = 0;
        @(negedge clk_i);
        n_chk++; if (outst_cnt !== 3'd2) $display("FAIL mrst_pre_cnt: got %0d want 2", outst_cnt); else n_pass++;
        data_gnt = 0; rst_i = 1;
        @(negedge clk_i);
        n_chk++; if (cmd_ready !== 1'b0) $display("FAIL mrst_ready: got %b want 0", cmd_ready); else n_pass++;
        n_chk++; if ({data_req, data_addr, outst_cnt, rsp_valid, proto_err} !== '0)
            $display("FAIL mrst_outputs: got req=%b addr=%h cnt=%0d rspv=%b perr=%b want all 0", data_req, data_addr, outst_cnt, rsp_valid, proto_err); else n_pass++;
        rst_i = 0; data_rvalid = 1; data_rdata = DW'(32'h5555);
        repeat (2) @(negedge clk_i);
        data_rvalid = 0;
        n_chk++; if ({rsp_valid, proto_err, outst_cnt} !== {1'b0, 1'b0, 3'd0})
            $display("FAIL mrst_stale: got rspv=%b perr=%b cnt=%0d want 0 0 0", rsp_valid, proto_err, outst_cnt); else n_pass++;
        @(negedge clk_i);
        n_chk++; if ({rsp_valid, proto_err} !== 2'b00) $display("FAIL mrst_stale_late: got rspv=%b perr=%b want 0 0", rsp_valid, proto_err); else n_pass++;
    endtask

    task automatic test_random();
        tcmd_t p;
        logic  exp_rdy;
        rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
        m_pend.delete(); m_infl.delete();
        m_rsp_vld = 0; m_rsp_we = 0; m_rsp_cap = 0; m_rsp_err = 0; m_rsp_rdata = '0;
        for (int c = 0; c < 400; c++) begin
            n_chk++; if (data_req !== (m_pend.size() > 0)) $display("FAIL rnd_req_%0d: got %b want %b", c, data_req, m_pend.size() > 0); else n_pass++;
            if (m_pend.size() > 0) begin
                p = m_pend[0];
                n_chk++; if ({data_we, data_is_cap, data_be, data_addr, data_wdata, data_flag} !== {p.we, p.cap, p.be, p.addr, p.wdata, p.flag})
                    $display("FAIL rnd_attr_%0d: got addr=%h wdata=%h want addr=%h wdata=%h", c, data_addr, data_wdata, p.addr, p.wdata); else n_pass++;
            end
            n_chk++; if (outst_cnt !== 3'(m_infl.size())) $display("FAIL rnd_cnt_%0d: got %0d want %0d", c, outst_cnt, m_infl.size()); else n_pass++;
            n_chk++; if (rsp_valid !== m_rsp_vld) $display("FAIL rnd_rspv_%0d: got %b want %b", c, rsp_valid, m_rsp_vld); else n_pass++;
            if (m_rsp_vld) begin
                n_chk++; if ({rsp_we, rsp_is_cap, rsp_err, rsp_rdata} !== {m_rsp_we, m_rsp_cap, m_rsp_err, m_rsp_rdata})
                    $display("FAIL rnd_rsp_%0d: got we=%b cap=%b err=%b rdata=%h want %b %b %b %h", c, rsp_we, rsp_is_cap, rsp_err, rsp_rdata, m_rsp_we, m_rsp_cap, m_rsp_err, m_rsp_rdata); else n_pass++;
            end
            n_chk++; if (proto_err !== 1'b0) $display("FAIL rnd_perr_%0d: got %b want 0", c, proto_err); else n_pass++;
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_we     = 1'($urandom_range(0, 1));
            cmd_is_cap = 1'($urandom_range(0, 1));
            cmd_be     = 4'($urandom());
            cmd_addr   = $urandom();
            cmd_wdata  = DW'({$urandom(), $urandom(), $urandom()});
            cmd_flag   = 8'($urandom());
            data_gnt   = ($urandom_range(0, 2) != 0);
            data_rvalid = (m_infl.size() > 0) && ($urandom_range(0, 1) == 1);
            data_rdata = DW'({$urandom(), $urandom(), $urandom()});
            data_err   = ($urandom_range(0, 7) == 0);
            #1;
            exp_rdy = (m_pend.size() == 0 || data_gnt) && (m_infl.size() + m_pend.size() < MAXO);
            n_chk++; if (cmd_ready !== exp_rdy) $display("FAIL rnd_ready_%0d: got %b want %b", c, cmd_ready, exp_rdy); else n_pass++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_i = 1;
        test_reset();
        test_single_read();
        test_write_stall();
        test_max_outstanding();
        test_gnt_rvalid_same_cycle();
        test_spurious_rvalid();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/obi_data_initiator.md
OBI_DATA_INITIATOR -- requirements
Module: obi_data_initiator

Interface
REQ-001 SHALL have parameter DW, default 65, meaning data width including the tag bit; legal values are 33 and 65.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of granted requests awaiting rvalid; legal range is 1..4.
REQ-003 SHALL have ports, in this order:
  clk_i  in  1  sole clock
  rst_i  in  1  synchronous, active-high reset
  cmd_valid / cmd_ready  in/out  1/1  command handshake
  cmd_we, cmd_is_cap  in  1 each  write and capability-access flags
  cmd_be  in  4  byte enables
  cmd_addr  in  32  byte address
  cmd_wdata  in  DW  write data
  cmd_flag  in  8  sideband flags (bit0 isr, bit2 stkz)
  data_req, data_we, data_is_cap  out  1 each  OBI request
  data_be / data_addr / data_wdata / data_flag  out  4/32/DW/8  OBI request attributes
  data_gnt, data_rvalid, data_err  in  1 each  OBI responder signals
  data_rdata  in  DW  OBI read data
  rsp_valid, rsp_we, rsp_is_cap, rsp_err  out  1 each  response
  rsp_rdata  out  DW  response read data
  outst_cnt  out  3  outstanding count
  proto_err  out  1  sticky protocol violation flag

Function
REQ-004 SHALL hold the accepted command in one request register; data_req SHALL equal that register's valid bit.
REQ-005 SHALL, while data_req=1 and data_gnt=0, keep data_req and all data_* attributes stable; the request SHALL NOT be retracted.
REQ-006 SHALL drive cmd_ready = (~data_req | data_gnt) & ((outst_cnt + data_req) < MAX_OUTSTANDING).
REQ-007 SHALL load the request register on cmd_valid & cmd_ready, so a back-to-back request is presented on the cycle after a grant.
REQ-008 SHALL clear the request register on data_gnt when no new command is accepted in the same cycle.
REQ-009 SHALL update outst_cnt as follows: +1 on (data_req & data_gnt), -1 on data_rvalid, unchanged when both occur in the same cycle.
REQ-010 SHALL push {we, is_cap} into an in-order tag FIFO of depth MAX_OUTSTANDING on each grant, and pop it on each data_rvalid.
REQ-011 SHALL register responses with 1-cycle latency: rsp_valid is asserted the cycle after data_rvalid, carrying data_rdata, data_err and the popped {we, is_cap}.
REQ-012 SHALL drive rsp_rdata to zero for write responses and SHALL pass rdata[DW-1] (the tag bit) unmodified for capability reads.
REQ-013 SHALL have no backpressure on rsp_*; the consumer SHALL accept a response every cycle.
REQ-014 SHALL set proto_err when data_rvalid arrives with outst_cnt=0, or when the FIFO push would overflow; proto_err SHALL stay set until reset, and an rvalid arriving with outst_cnt=0 SHALL leave both the count and the FIFO unchanged.
REQ-015 SHALL have no internal request-side state beyond IDLE (register empty) and REQ (register valid); IDLE->REQ on accept, REQ->IDLE on grant without a new accept, REQ->REQ on grant with a new accept.

Reset
REQ-016 SHALL, on rst_i=1 at a clk_i edge, clear the request register, outst_cnt, the FIFO pointers, rsp_valid and proto_err; all outputs SHALL read 0 during and after reset.
REQ-017 SHALL discard transactions in flight at a mid-operation reset; no rsp_valid SHALL be produced for them, and proto_err SHALL remain 0 if a stale rvalid arrives within MAX_OUTSTANDING cycles after reset release.
REQ-018 SHALL keep cmd_ready at 0 while rst_i=1.

Structure
REQ-019 SHALL take mem_cmd_t and the flag-bit index constants (FLAG_ISR=0, FLAG_STKZ=2) from kudu_dv_pkg; no new package SHALL be created.
REQ-020 SHALL implement the tag FIFO as sub-module obi_tag_fifo (parameters WIDTH and DEPTH, flop-based, with full/empty outputs).

Verification
REQ-021 Single read, addr 0x8000_0010, gnt immediate, rvalid 2 cycles later with rdata 0x1234_5678 -> rsp_valid exactly 1 cycle after rvalid with rsp_rdata 0x1234_5678, rsp_we=0, outst_cnt back to 0.
REQ-022 Write stall, gnt withheld 5 cycles -> data_req and attributes stable for all 6 cycles, cmd_ready=0 throughout, rsp_we=1 and rsp_rdata=0 on completion.
REQ-023 MAX_OUTSTANDING=2 with three queued commands and rvalid delayed -> third data_req not asserted until the first rvalid; outst_cnt never exceeds 2.
REQ-024 Grant and rvalid in the same cycle -> outst_cnt unchanged; response tags returned in issue order (read, write, cap-read).
REQ-025 Spurious rvalid with outst_cnt=0 -> proto_err=1 and held until rst_i; no rsp_valid produced.
REQ-026 rst_i asserted with 2 requests outstanding -> all outputs 0 next cycle, late rvalid ignored, proto_err stays 0.
